// File: rtl/bcd_reaction_counter.sv
// Reaction-timer elapsed counter: packed BCD millisecond count with
// start/stop/clear control, hold-after-stop and all-nines saturation.
module bcd_reaction_counter #(
  parameter int N_DIGITS = 4,
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  output logic [N_DIGITS*4-1:0] bcd_out,
  output logic                  running,
  output logic                  done,
  output logic                  overflow
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic [N_DIGITS*4-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                    ovf_q, ovf_d;
  logic                    tick;
  logic                    all_nines;
  logic                    carry;

  // Ripple BCD increment; a digit only advances when all lower digits are 9.
  always_comb begin
    cnt_inc   = cnt_q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (cnt_q[i*4 +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (cnt_q[i*4 +: 4] == 4'd9) begin
          cnt_inc[i*4 +: 4] = 4'd0;
        end else begin
          cnt_inc[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign tick = (pre_q == PRE_MAX);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      pre_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d = RUN;
            pre_d   = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = HOLD;
          end else if (tick) begin
            pre_d = '0;
            if (all_nines) begin
              ovf_d   = 1'b1;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd_out  = cnt_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == HOLD);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_reaction_counter.sv
// Randomised and directed bench for bcd_reaction_counter against an
// elapsed-cycle reference model (two instances: 2-digit/div10, 4-digit/div1).
module tb_bcd_reaction_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_start = 0, a_stop = 0, a_clear = 0;
  logic b_start = 0, b_stop = 0, b_clear = 0;
  logic [7:0]  a_bcd;
  logic [15:0] b_bcd;
  logic a_run, a_done, a_ovf;
  logic b_run, b_done, b_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_reaction_counter #(.N_DIGITS(2), .CLK_HZ(10), .TICK_HZ(1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .clear(a_clear),
    .bcd_out(a_bcd), .running(a_run), .done(a_done), .overflow(a_ovf)
  );

  bcd_reaction_counter #(.N_DIGITS(4), .CLK_HZ(1000), .TICK_HZ(1000)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .clear(b_clear),
    .bcd_out(b_bcd), .running(b_run), .done(b_done), .overflow(b_ovf)
  );

  // Model: st 0=idle 1=run 2=hold; r = RUN edges since start.
  typedef struct {
    int st;
    int r;
    bit ovf;
  } m_t;

  m_t ma, mb;

  function automatic m_t mstep(m_t m, bit s, bit p, bit c,
                               int div, int maxc);
    if (c) begin
      m.st = 0; m.r = 0; m.ovf = 0;
    end else if (m.st == 0) begin
      if (s) begin m.st = 1; m.r = 0; end
    end else if (m.st == 1) begin
      if (p) m.st = 2;
      else begin
        m.r++;
        if (m.r / div > maxc) begin
          m.ovf = 1; m.st = 2;
        end
      end
    end
    return m;
  endfunction

  function automatic logic [31:0] to_bcd(int v, int n);
    logic [31:0] b;
    int p;
    b = '0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      b[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return b;
  endfunction

  function automatic int mcount(m_t m, int div, int maxc);
    int c;
    c = m.r / div;
    return (c > maxc) ? maxc : c;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit digits_ok(logic [31:0] v, int n);
    bit ok;
    ok = 1;
    for (int i = 0; i < n; i++)
      if (v[i*4 +: 4] > 4'd9) ok = 0;
    return ok;
  endfunction

  task automatic cmp_all();
    chk("a_bcd", a_bcd, to_bcd(mcount(ma, 10, 99), 2));
    chk("a_run", a_run, ma.st == 1);
    chk("a_done", a_done, ma.st == 2);
    chk("a_ovf", a_ovf, ma.ovf);
    chk("a_digits", digits_ok(a_bcd, 2), 1);
    chk("b_bcd", b_bcd, to_bcd(mcount(mb, 1, 9999), 4));
    chk("b_run", b_run, mb.st == 1);
    chk("b_done", b_done, mb.st == 2);
    chk("b_ovf", b_ovf, mb.ovf);
    chk("b_digits", digits_ok(b_bcd, 4), 1);
  endtask

  // One clock: sample inputs at the edge, advance models, compare at +1.
  task automatic tick();
    bit as, ap, ac, bs, bp, bc;
    as = a_start; ap = a_stop; ac = a_clear;
    bs = b_start; bp = b_stop; bc = b_clear;
    @(posedge clk);
    ma = mstep(ma, as, ap, ac, 10, 99);
    mb = mstep(mb, bs, bp, bc, 1, 9999);
    #1;
    cmp_all();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_a(bit s, bit p, bit c);
    a_start = s; a_stop = p; a_clear = c;
  endtask

  task automatic model_reset();
    ma = '{0, 0, 0};
    mb = '{0, 0, 0};
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_a_bcd", a_bcd, 0);
    chk("rst_a_flags", {a_run, a_done, a_ovf}, 0);
    chk("rst_b_bcd", b_bcd, 0);
    #1 rst = 1'b0;

    // Basic count
    set_a(1, 0, 0); tick();
    set_a(0, 0, 0); ticks(120);
    chk("basic120", a_bcd, 8'h12);
    chk("basic120_run", a_run, 1);
    ticks(5);
    chk("basic125", a_bcd, 8'h12);

    // Asynchronous reset between edges, mid-RUN
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_bcd", a_bcd, 0);
    chk("arst_flags", {a_run, a_done, a_ovf}, 0);
    #1 rst = 1'b0;
    tick();

    // Stop on the prescaler==9 cycle at count 07
    set_a(1, 0, 0); tick();
    set_a(0, 0, 0); ticks(79);
    chk("pre_stop", a_bcd, 8'h07);
    set_a(0, 1, 0); tick();
    set_a(0, 0, 0); ticks(3);
    chk("hold_bcd", a_bcd, 8'h07);
    chk("hold_flags", {a_run, a_done}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      set_a(1, 0, 0); tick();
      set_a(0, 0, 0); ticks(12);
    end
    chk("hold_start", a_bcd, 8'h07);
    chk("hold_done", a_done, 1);

    // Carry chain up to 99 then saturate
    set_a(0, 0, 1); tick();
    set_a(1, 0, 0); tick();
    set_a(0, 0, 0); ticks(999);
    chk("at99", a_bcd, 8'h99);
    chk("at99_ovf", a_ovf, 0);
    ticks(10);
    chk("sat_bcd", a_bcd, 8'h99);
    chk("sat_flags", {a_ovf, a_done, a_run}, 3'b110);
    set_a(0, 0, 1); tick();
    set_a(0, 0, 0);
    chk("clr_bcd", a_bcd, 0);
    chk("clr_flags", {a_ovf, a_done, a_run}, 0);

    // Priority of clear
    set_a(1, 0, 1); tick();
    set_a(0, 0, 0);
    chk("clr_start", a_run, 0);
    set_a(1, 0, 0); tick();
    set_a(0, 0, 0); ticks(30);
    set_a(0, 1, 1); tick();
    set_a(0, 0, 0);
    chk("clr_stop_bcd", a_bcd, 0);
    chk("clr_stop_st", {a_run, a_done}, 0);

    // Four digits, divide-by-one
    b_start = 1; tick();
    b_start = 0; ticks(1000);
    chk("b_1000", b_bcd, 16'h1000);
    b_clear = 1; tick();
    b_clear = 0;

    // Random control on both instances
    for (int i = 0; i < 3000; i++) begin
      a_start = ($urandom_range(0, 19) == 0);
      a_stop  = ($urandom_range(0, 149) == 0);
      a_clear = ($urandom_range(0, 399) == 0);
      b_start = ($urandom_range(0, 9) == 0);
      b_stop  = ($urandom_range(0, 299) == 0);
      b_clear = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
